// File: rtl/pktgen_pkg.sv
// Shared constants, state encoding and helpers for the multi-flow
// Ethernet frame generator.
package pktgen_pkg;

    localparam int unsigned DST_OFF         = 0;
    localparam int unsigned SRC_OFF         = 6;
    localparam int unsigned ETYPE_OFF       = 12;
    localparam int unsigned TCI_OFF         = 14;
    localparam int unsigned INNER_ETYPE_OFF = 16;
    localparam int unsigned VER_OFF         = 14;
    localparam int unsigned TOS_OFF         = 15;
    localparam int unsigned SEQ_OFF_VLAN    = 18;
    localparam int unsigned SEQ_OFF_PLAIN   = 16;

    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1522;
    localparam int unsigned BEAT_W  = 8;

    localparam logic [15:0] ETH_VLAN = 16'h8100;
    localparam logic [15:0] ETH_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    function automatic int unsigned flow_len(
        input int unsigned base,
        input int unsigned step,
        input int unsigned f
    );
        return base + f * step;
    endfunction

endpackage

// File: rtl/packet_generator_multiflow_if.sv
// AXI4-Stream bundle carrying generated frames from source to sink.
// The source drives data and qualifiers; the sink drives tready.
interface packet_generator_multiflow_if #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned TUSER_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/pktgen_beat_builder.sv
// Combinational builder for one stream beat of a flow's frame.
// Lanes past the end of the frame are zero with tkeep cleared.
module pktgen_beat_builder
    import pktgen_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 256,
    parameter logic [47:0] DST_MAC_BASE    = 48'h1111_1111_1100,
    parameter logic [47:0] SRC_MAC_ADDR    = 48'h2222_2222_2222,
    parameter int unsigned VLAN            = 1,
    parameter int unsigned PACKET_LENGTH   = 70,
    parameter int unsigned LEN_STEP        = 8
) (
    input  logic [2:0]                   flow,
    input  logic [BEAT_W-1:0]            beat,
    input  logic [31:0]                  seq,
    output logic [AXIS_DATA_WIDTH-1:0]   tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] tkeep,
    output logic                         tlast
);

    localparam int unsigned B = AXIS_DATA_WIDTH / 8;

    int unsigned len;
    int unsigned base;

    assign len  = flow_len(PACKET_LENGTH, LEN_STEP, {29'b0, flow});
    assign base = {24'b0, beat} * B;

    function automatic logic [7:0] byte_at(
        input int unsigned i,
        input logic [2:0]  f,
        input logic [31:0] sq
    );
        logic [47:0] dst;
        logic [7:0]  b;
        int unsigned so;
        dst = DST_MAC_BASE + {45'b0, f};
        so  = (VLAN != 0) ? SEQ_OFF_VLAN : SEQ_OFF_PLAIN;
        b   = i[7:0];
        if (i < SRC_OFF) begin
            b = 8'(dst >> (8 * (SRC_OFF - 1 - (i - DST_OFF))));
        end else if (i < ETYPE_OFF) begin
            b = 8'(SRC_MAC_ADDR >> (8 * (ETYPE_OFF - 1 - i)));
        end else if (i >= so && i < so + 4) begin
            b = 8'(sq >> (8 * (so + 3 - i)));
        end else if (VLAN != 0) begin
            if (i == ETYPE_OFF)           b = ETH_VLAN[15:8];
            if (i == ETYPE_OFF + 1)       b = ETH_VLAN[7:0];
            if (i == TCI_OFF)             b = {f, 5'b0};
            if (i == TCI_OFF + 1)         b = 8'h00;
            if (i == INNER_ETYPE_OFF)     b = ETH_IPV4[15:8];
            if (i == INNER_ETYPE_OFF + 1) b = ETH_IPV4[7:0];
        end else begin
            if (i == ETYPE_OFF)     b = ETH_IPV4[15:8];
            if (i == ETYPE_OFF + 1) b = ETH_IPV4[7:0];
            if (i == VER_OFF)       b = 8'h45;
            if (i == TOS_OFF)       b = {3'b0, f, 2'b00};
        end
        return b;
    endfunction

    // Fill each lane that still falls inside the frame.
    always_comb begin
        tdata = '0;
        tkeep = '0;
        for (int unsigned l = 0; l < B; l++) begin
            if (base + l < len) begin
                tdata[l*8 +: 8] = byte_at(base + l, flow, seq);
                tkeep[l]        = 1'b1;
            end
        end
        tlast = (base + B >= len);
    end

endmodule

// File: rtl/packet_generator_multiflow.sv
// Round-robin multi-flow Ethernet frame source on AXI4-Stream.
// One whole frame per flow turn, optional gap, finite frame budget.
module packet_generator_multiflow
    import pktgen_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH  = 256,
    parameter int unsigned AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_FLOWS        = 4,
    parameter logic [47:0] DST_MAC_BASE     = 48'h1111_1111_1100,
    parameter logic [47:0] SRC_MAC_ADDR     = 48'h2222_2222_2222,
    parameter int unsigned VLAN             = 1,
    parameter int unsigned PACKET_LENGTH    = 70,
    parameter int unsigned LEN_STEP         = 8,
    parameter int unsigned NUM_PACKETS      = 16,
    parameter int unsigned IFG_CYCLES       = 2
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic                          enable,
    packet_generator_multiflow_if.master  m_axis,
    output logic                          done,
    output logic [31:0]                   frames_sent
);

    localparam int unsigned KW = AXIS_DATA_WIDTH / 8;
    localparam int unsigned LEN_TOP =
        flow_len(PACKET_LENGTH, LEN_STEP, NUM_FLOWS - 1);

    if (AXIS_DATA_WIDTH % 64 != 0 || AXIS_TUSER_WIDTH < 32 ||
        NUM_FLOWS < 1 || NUM_FLOWS > 8) begin : g_bad_cfg
        $error("packet_generator_multiflow: bad width or flow count");
    end

    if (LEN_TOP > MAX_LEN || PACKET_LENGTH < MIN_LEN) begin : g_bad_len
        $error("packet_generator_multiflow: frame length out of range");
    end

    state_t                      state;
    logic [2:0]                  ptr;
    logic [BEAT_W-1:0]           beat_nxt;
    logic [15:0]                 gap_cnt;
    logic [31:0]                 seq_q [8];

    logic [AXIS_DATA_WIDTH-1:0]  tdata_q;
    logic [KW-1:0]               tkeep_q;
    logic [AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic                        tvalid_q;
    logic                        tlast_q;

    logic [BEAT_W-1:0]           bld_beat;
    logic [AXIS_DATA_WIDTH-1:0]  bld_tdata;
    logic [KW-1:0]               bld_tkeep;
    logic                        bld_tlast;
    logic [AXIS_TUSER_WIDTH-1:0] tuser_nxt;

    logic [2:0]                  nxt_ptr;
    logic                        nxt_found;
    logic [2:0]                  cand;
    logic [31:0]                 cnt;
    logic                        any_left;

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    assign bld_beat = (state == SEND) ? beat_nxt : '0;

    pktgen_beat_builder #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .DST_MAC_BASE    (DST_MAC_BASE),
        .SRC_MAC_ADDR    (SRC_MAC_ADDR),
        .VLAN            (VLAN),
        .PACKET_LENGTH   (PACKET_LENGTH),
        .LEN_STEP        (LEN_STEP)
    ) u_builder (
        .flow  (ptr),
        .beat  (bld_beat),
        .seq   (seq_q[ptr]),
        .tdata (bld_tdata),
        .tkeep (bld_tkeep),
        .tlast (bld_tlast)
    );

    // Sideband for the frame about to start: length and flow id.
    always_comb begin
        tuser_nxt        = '0;
        tuser_nxt[15:0]  = 16'(flow_len(PACKET_LENGTH, LEN_STEP, {29'b0, ptr}));
        tuser_nxt[18:16] = ptr;
    end

    // Next flow after the current one that still has budget,
    // counting the frame that is completing right now.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ptr   = ptr;
        cand      = '0;
        cnt       = '0;
        for (int k = int'(NUM_FLOWS); k > 0; k--) begin
            cand = 3'((int'(ptr) + k) % int'(NUM_FLOWS));
            cnt  = seq_q[cand] + ((cand == ptr) ? 32'd1 : 32'd0);
            if (NUM_PACKETS == 0 || cnt < NUM_PACKETS) begin
                nxt_ptr   = cand;
                nxt_found = 1'b1;
            end
        end
    end

    // True while at least one flow may still send a frame.
    always_comb begin
        any_left = (NUM_PACKETS == 0);
        for (int f = 0; f < int'(NUM_FLOWS); f++) begin
            if (seq_q[3'(f)] < NUM_PACKETS) any_left = 1'b1;
        end
    end

    // Frame sequencer: boundary decisions, beat advance, gap, done.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state       <= IDLE;
            ptr         <= '0;
            beat_nxt    <= '0;
            gap_cnt     <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            for (int i = 0; i < 8; i++) seq_q[i] <= '0;
        end else begin
            unique case (state)
                IDLE, GAP: begin
                    if (state == GAP && gap_cnt != 0) begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end else if (!any_left) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (enable) begin
                        tdata_q  <= bld_tdata;
                        tkeep_q  <= bld_tkeep;
                        tlast_q  <= bld_tlast;
                        tuser_q  <= tuser_nxt;
                        tvalid_q <= 1'b1;
                        beat_nxt <= BEAT_W'(1);
                        state    <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (tvalid_q && m_axis.tready) begin
                        if (tlast_q) begin
                            seq_q[ptr]  <= seq_q[ptr] + 32'd1;
                            frames_sent <= frames_sent + 32'd1;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= '0;
                            tkeep_q     <= '0;
                            tuser_q     <= '0;
                            if (nxt_found) ptr <= nxt_ptr;
                            if (IFG_CYCLES != 0) begin
                                state   <= GAP;
                                gap_cnt <= 16'(IFG_CYCLES - 1);
                            end else if (nxt_found) begin
                                state <= IDLE;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            tdata_q  <= bld_tdata;
                            tkeep_q  <= bld_tkeep;
                            tlast_q  <= bld_tlast;
                            beat_nxt <= beat_nxt + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_generator_multiflow.sv
// Directed bench for the multi-flow frame generator: a 4-flow instance
// for framing/backpressure/enable/reset and a 2-flow budget instance.
module tb_packet_generator_multiflow;

    logic        clk = 1'b0;
    logic        rst1, rst2, en1, en2, rdy1, rdy2;
    logic        done1, done2;
    logic [31:0] fs1, fs2;

    int npass = 0;
    int ntot  = 0;

    packet_generator_multiflow_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) ax1 ();
    packet_generator_multiflow_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) ax2 ();

    assign ax1.tready = rdy1;
    assign ax2.tready = rdy2;

    packet_generator_multiflow u_dut1 (
        .axis_aclk   (clk),
        .axis_reset  (rst1),
        .enable      (en1),
        .m_axis      (ax1.master),
        .done        (done1),
        .frames_sent (fs1)
    );

    packet_generator_multiflow #(
        .NUM_FLOWS   (2),
        .NUM_PACKETS (3)
    ) u_dut2 (
        .axis_aclk   (clk),
        .axis_reset  (rst2),
        .enable      (en2),
        .m_axis      (ax2.master),
        .done        (done2),
        .frames_sent (fs2)
    );

    always #5 clk = ~clk;

    // reference model state for dut1
    int          nf;
    logic [31:0] sq [4];
    int          total;

    // capture results
    logic [7:0]   cap_bytes [2048];
    int           cap_n, cap_beats, cap_wait, cap_keep_err, cap_hold_err;
    logic [127:0] cap_user;
    logic [31:0]  cap_keep_last;
    bit           cap_to;

    function automatic int exp_len(int f);
        return 70 + 8 * f;
    endfunction

    function automatic logic [31:0] exp_keep(int f);
        int r;
        r = exp_len(f) % 32;
        if (r == 0) return 32'hFFFF_FFFF;
        return (32'd1 << r) - 32'd1;
    endfunction

    function automatic logic [7:0] exp_byte(int f, logic [31:0] s, int i);
        logic [47:0] dmac;
        logic [7:0]  r;
        dmac = 48'h1111_1111_1100 + 48'(f);
        if (i < 6) return dmac[47 - 8*i -: 8];
        if (i < 12) return 8'h22;
        case (i)
            12: r = 8'h81;
            13: r = 8'h00;
            14: r = {f[2:0], 5'b0};
            15: r = 8'h00;
            16: r = 8'h08;
            17: r = 8'h00;
            18: r = s[31:24];
            19: r = s[23:16];
            20: r = s[15:8];
            21: r = s[7:0];
            default: r = i[7:0];
        endcase
        return r;
    endfunction

    function automatic int count_bad(int f, logic [31:0] s);
        int bad = 0;
        for (int i = 0; i < cap_n; i++)
            if (cap_bytes[i] !== exp_byte(f, s, i)) bad++;
        if (cap_n != exp_len(f)) bad++;
        return bad;
    endfunction

    function automatic logic [127:0] exp_user(int f);
        return {109'd0, 3'(f), 16'(exp_len(f))};
    endfunction

    task automatic advance();
        total++;
        sq[nf] = sq[nf] + 32'd1;
        nf = (nf + 1) % 4;
    endtask

    task automatic capture(input int pct, input bit drop);
        logic [255:0] pd, mask;
        logic [31:0]  pk;
        logic         pl;
        bit           hold, fin;
        int           budget;
        cap_n = 0; cap_beats = 0; cap_wait = 0;
        cap_keep_err = 0; cap_hold_err = 0; cap_to = 0;
        cap_user = '0; cap_keep_last = '0;
        hold = 0; fin = 0; budget = 0;
        pd = '0; pk = '0; pl = 1'b0;
        while (!fin && budget < 3000) begin
            @(negedge clk);
            budget++;
            rdy1 = (int'($urandom_range(99)) < pct);
            if (hold && (ax1.tvalid !== 1'b1 || ax1.tdata !== pd ||
                         ax1.tkeep !== pk || ax1.tlast !== pl))
                cap_hold_err++;
            hold = 0;
            if (ax1.tvalid !== 1'b1) begin
                if (cap_beats == 0) cap_wait++;
            end else if (rdy1) begin
                if (cap_beats == 0) cap_user = ax1.tuser;
                mask = '0;
                for (int l = 0; l < 32; l++) begin
                    if (ax1.tkeep[l]) begin
                        mask[l*8 +: 8] = 8'hFF;
                        if (cap_n < 2048) cap_bytes[cap_n] = ax1.tdata[l*8 +: 8];
                        cap_n++;
                    end
                end
                if ((ax1.tdata & ~mask) != '0) cap_keep_err++;
                if ((ax1.tkeep & (ax1.tkeep + 32'd1)) != '0) cap_keep_err++;
                if (!ax1.tlast && ax1.tkeep !== 32'hFFFF_FFFF) cap_keep_err++;
                cap_beats++;
                if (drop && cap_beats == 1) en1 = 1'b0;
                if (ax1.tlast) begin
                    fin = 1;
                    cap_keep_last = ax1.tkeep;
                end
            end else begin
                hold = 1;
                pd = ax1.tdata;
                pk = ax1.tkeep;
                pl = ax1.tlast;
            end
        end
        if (!fin) cap_to = 1;
        rdy1 = 1'b1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        ntot++; if (ax1.tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", ax1.tvalid); else npass++;
        ntot++; if (ax1.tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", ax1.tlast); else npass++;
        ntot++; if (ax1.tdata !== '0) $display("FAIL rst_tdata got %h want 0", ax1.tdata); else npass++;
        ntot++; if (ax1.tkeep !== '0) $display("FAIL rst_tkeep got %h want 0", ax1.tkeep); else npass++;
        ntot++; if (ax1.tuser !== '0) $display("FAIL rst_tuser got %h want 0", ax1.tuser); else npass++;
        ntot++; if (done1 !== 1'b0) $display("FAIL rst_done got %b want 0", done1); else npass++;
        ntot++; if (fs1 !== 32'd0) $display("FAIL rst_frames got %0d want 0", fs1); else npass++;
    endtask

    task automatic test_first_frame();
        nf = 0; total = 0;
        for (int i = 0; i < 4; i++) sq[i] = '0;
        en1 = 1'b1;
        rdy1 = 1'b1;
        rst1 = 1'b0;
        capture(100, 0);
        ntot++; if (cap_to !== 1'b0) $display("FAIL ff_timeout got %b want 0", cap_to); else npass++;
        ntot++; if (cap_wait !== 0) $display("FAIL ff_latency got %0d want 0", cap_wait); else npass++;
        ntot++; if (cap_beats !== 3) $display("FAIL ff_beats got %0d want 3", cap_beats); else npass++;
        ntot++; if (cap_keep_last !== 32'h0000_003F) $display("FAIL ff_lastkeep got %h want 0000003f", cap_keep_last); else npass++;
        ntot++; if (cap_user !== {109'd0, 3'd0, 16'd70}) $display("FAIL ff_tuser got %h want 70 flow 0", cap_user); else npass++;
        ntot++; if (count_bad(0, 32'd0) !== 0) $display("FAIL ff_bytes got %0d bad want 0", count_bad(0, 32'd0)); else npass++;
        ntot++; if (cap_keep_err !== 0) $display("FAIL ff_keepfmt got %0d want 0", cap_keep_err); else npass++;
        advance();
    endtask

    task automatic test_flow_order();
        for (int k = 0; k < 4; k++) begin
            capture(100, 0);
            if (k == 0) begin
                ntot++; if (cap_wait !== 2) $display("FAIL ifg_cycles got %0d want 2", cap_wait); else npass++;
            end
            ntot++; if (cap_to !== 1'b0) $display("FAIL ord_timeout got %b want 0", cap_to); else npass++;
            ntot++; if (cap_user !== exp_user(nf)) $display("FAIL ord_tuser got %h want %h", cap_user, exp_user(nf)); else npass++;
            ntot++; if (cap_keep_last !== exp_keep(nf)) $display("FAIL ord_lastkeep got %h want %h", cap_keep_last, exp_keep(nf)); else npass++;
            ntot++; if (count_bad(nf, sq[nf]) !== 0) $display("FAIL ord_bytes flow %0d got %0d bad", nf, count_bad(nf, sq[nf])); else npass++;
            if (nf == 1) begin
                ntot++; if (cap_keep_last !== 32'h0000_3FFF) $display("FAIL f1_keep got %h want 00003fff", cap_keep_last); else npass++;
                ntot++; if (cap_bytes[5] !== 8'h01) $display("FAIL f1_dst got %h want 01", cap_bytes[5]); else npass++;
                ntot++; if (cap_bytes[14] !== 8'h20) $display("FAIL f1_pcp got %h want 20", cap_bytes[14]); else npass++;
                ntot++; if (cap_user[18:0] !== {3'd1, 16'd78}) $display("FAIL f1_tuser got %h want 1/78", cap_user[18:0]); else npass++;
            end
            if (nf == 0) begin
                ntot++; if ({cap_bytes[18], cap_bytes[19], cap_bytes[20], cap_bytes[21]} !== 32'h0000_0001)
                    $display("FAIL f0_seq got %h%h%h%h want 00000001", cap_bytes[18], cap_bytes[19], cap_bytes[20], cap_bytes[21]);
                else npass++;
            end
            advance();
        end
        @(negedge clk);
        ntot++; if (fs1 !== 32'(total)) $display("FAIL ord_frames got %0d want %0d", fs1, total); else npass++;
    endtask

    task automatic test_backpressure();
        repeat (8) begin
            capture(50, 0);
            ntot++; if (cap_to !== 1'b0) $display("FAIL bp_timeout got %b want 0", cap_to); else npass++;
            ntot++; if (cap_hold_err !== 0) $display("FAIL bp_hold got %0d changes want 0", cap_hold_err); else npass++;
            ntot++; if (cap_user !== exp_user(nf)) $display("FAIL bp_tuser got %h want %h", cap_user, exp_user(nf)); else npass++;
            ntot++; if (count_bad(nf, sq[nf]) !== 0) $display("FAIL bp_bytes flow %0d got %0d bad", nf, count_bad(nf, sq[nf])); else npass++;
            ntot++; if (cap_keep_err !== 0) $display("FAIL bp_keepfmt got %0d want 0", cap_keep_err); else npass++;
            advance();
        end
    endtask

    task automatic test_enable_drop();
        int highs = 0;
        capture(100, 1);
        ntot++; if (cap_to !== 1'b0) $display("FAIL en_timeout got %b want 0", cap_to); else npass++;
        ntot++; if (count_bad(nf, sq[nf]) !== 0) $display("FAIL en_bytes got %0d bad want 0", count_bad(nf, sq[nf])); else npass++;
        advance();
        repeat (20) begin
            @(negedge clk);
            if (ax1.tvalid === 1'b1) highs++;
        end
        ntot++; if (highs !== 0) $display("FAIL en_stopped got %0d valid cycles want 0", highs); else npass++;
        en1 = 1'b1;
        capture(100, 0);
        ntot++; if (cap_wait !== 0) $display("FAIL en_resume_lat got %0d want 0", cap_wait); else npass++;
        ntot++; if (cap_user !== exp_user(nf)) $display("FAIL en_resume_flow got %h want %h", cap_user, exp_user(nf)); else npass++;
        ntot++; if (count_bad(nf, sq[nf]) !== 0) $display("FAIL en_resume_bytes got %0d bad", count_bad(nf, sq[nf])); else npass++;
        advance();
    endtask

    task automatic test_reset_mid();
        int w = 0;
        rdy1 = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (ax1.tvalid !== 1'b1 && w < 50);
        @(negedge clk);
        ntot++; if (ax1.tvalid !== 1'b1) $display("FAIL rm_beat2 got %b want 1", ax1.tvalid); else npass++;
        #2 rst1 = 1'b1;
        #1;
        ntot++; if (ax1.tvalid !== 1'b0) $display("FAIL rm_async_tvalid got %b want 0", ax1.tvalid); else npass++;
        ntot++; if (ax1.tdata !== '0) $display("FAIL rm_async_tdata got %h want 0", ax1.tdata); else npass++;
        ntot++; if (fs1 !== 32'd0) $display("FAIL rm_frames got %0d want 0", fs1); else npass++;
        @(negedge clk);
        rst1 = 1'b0;
        nf = 0; total = 0;
        for (int i = 0; i < 4; i++) sq[i] = '0;
        capture(100, 0);
        ntot++; if (cap_wait !== 0) $display("FAIL rm_restart_lat got %0d want 0", cap_wait); else npass++;
        ntot++; if (cap_user !== exp_user(0)) $display("FAIL rm_flow got %h want %h", cap_user, exp_user(0)); else npass++;
        ntot++; if (count_bad(0, 32'd0) !== 0) $display("FAIL rm_bytes got %0d bad want 0", count_bad(0, 32'd0)); else npass++;
        advance();
        @(negedge clk);
        ntot++; if (fs1 !== 32'd1) $display("FAIL rm_frames_after got %0d want 1", fs1); else npass++;
    endtask

    task automatic test_done();
        int cyc = 0, hs = 0, hs_cyc = -1, done_cyc = -1, after = 0, f0 = 0;
        ntot++; if (done2 !== 1'b0) $display("FAIL dn_rst_done got %b want 0", done2); else npass++;
        ntot++; if (fs2 !== 32'd0) $display("FAIL dn_rst_frames got %0d want 0", fs2); else npass++;
        rdy2 = 1'b1;
        en2 = 1'b1;
        rst2 = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done2 === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (ax2.tvalid === 1'b1 && done2 === 1'b1) after++;
            if (ax2.tvalid === 1'b1 && ax2.tlast === 1'b1) begin
                hs++;
                if (ax2.tuser[18:16] == 3'd0) f0++;
                if (hs == 6) hs_cyc = cyc;
            end
        end
        ntot++; if (hs !== 6) $display("FAIL dn_frames got %0d want 6", hs); else npass++;
        ntot++; if (f0 !== 3) $display("FAIL dn_flow0 got %0d want 3", f0); else npass++;
        ntot++; if (done_cyc - hs_cyc !== 3) $display("FAIL dn_delay got %0d want 3", done_cyc - hs_cyc); else npass++;
        ntot++; if (fs2 !== 32'd6) $display("FAIL dn_frames_sent got %0d want 6", fs2); else npass++;
        ntot++; if (done2 !== 1'b1) $display("FAIL dn_done got %b want 1", done2); else npass++;
        ntot++; if (after !== 0) $display("FAIL dn_valid_after got %0d want 0", after); else npass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        en1 = 1'b0;  en2 = 1'b1;
        rdy1 = 1'b1; rdy2 = 1'b1;
        nf = 0; total = 0;
        for (int i = 0; i < 4; i++) sq[i] = '0;
        test_reset();
        test_first_frame();
        test_flow_order();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_done();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
